// File: rtl/pipe_scroller.sv
// Single-pipe generator for the game: an IDLE/RUN/HALT controller that scrolls the pipe left on
// every frame tick, respawns it at the right edge with an LFSR-chosen gap height, and counts the
// pipes that pass the bird. A collision from the downstream stage freezes the pipe in HALT.
module pipe_scroller #(
  parameter int unsigned WIDTH      = 10,
  parameter int unsigned HEIGHT     = 10,
  parameter int unsigned SCREEN_W   = 640,
  parameter int unsigned PIPE_WIDTH = 40,
  parameter int unsigned BIRD_X     = 100,
  parameter int unsigned SPEED      = 2,
  parameter int unsigned GAP_MIN    = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              collision,
  output logic [WIDTH-1:0]  pipe_x,
  output logic [HEIGHT-1:0] pipe_y,
  output logic              pipe_valid,
  output logic              running,
  output logic              score_pulse,
  output logic [7:0]        score
);

  localparam logic [WIDTH-1:0]  ScreenW   = WIDTH'(SCREEN_W);
  localparam logic [WIDTH-1:0]  SpeedW    = WIDTH'(SPEED);
  localparam logic [WIDTH:0]    PipeWExt  = (WIDTH + 1)'(PIPE_WIDTH);
  localparam logic [WIDTH:0]    BirdXExt  = (WIDTH + 1)'(BIRD_X);
  localparam logic [HEIGHT-1:0] GapMinH   = HEIGHT'(GAP_MIN);
  localparam logic [15:0]       LfsrSeed  = 16'hACE1;
  localparam logic [15:0]       LfsrMask  = 16'hB400;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StHalt
  } state_e;

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  x_q, x_d;
  logic [HEIGHT-1:0] y_q, y_d;
  logic [7:0]        score_q, score_d;
  logic              pulse_q, pulse_d;
  logic [15:0]       lfsr_q, lfsr_d;

  logic [15:0]       lfsr_next;
  logic [HEIGHT-1:0] gap_y;
  logic [WIDTH-1:0]  x_step;
  logic [WIDTH:0]    old_right;
  logic [WIDTH:0]    new_right;
  logic              passes_bird;
  logic              at_left_edge;

  // Datapath helpers: next LFSR value, candidate gap height, scrolled position and scoring test.
  always_comb begin
    lfsr_next    = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LfsrMask : 16'h0000);
    gap_y        = GapMinH + HEIGHT'(lfsr_q[7:0]);
    x_step       = x_q - SpeedW;
    // Right-edge sums carry an extra bit so x near the top of the range cannot wrap.
    old_right    = {1'b0, x_q} + PipeWExt;
    new_right    = {1'b0, x_step} + PipeWExt;
    passes_bird  = (old_right > BirdXExt) && (new_right <= BirdXExt);
    at_left_edge = (x_q <= SpeedW);
  end

  // Next-state logic: game controller plus pipe position, gap, score and pulse updates.
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    score_d = score_q;
    lfsr_d  = lfsr_q;
    pulse_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StRun;
          x_d     = ScreenW;
          y_d     = gap_y;
          lfsr_d  = lfsr_next;
          score_d = 8'd0;
        end
      end

      StRun: begin
        // Collision wins over a same-cycle tick: the pipe freezes where it is.
        if (collision) begin
          state_d = StHalt;
        end else if (frame_tick) begin
          if (at_left_edge) begin
            x_d    = ScreenW;
            y_d    = gap_y;
            lfsr_d = lfsr_next;
          end else begin
            x_d = x_step;
            if (passes_bird) begin
              pulse_d = 1'b1;
              if (score_q != 8'hFF) begin
                score_d = score_q + 8'd1;
              end
            end
          end
        end
      end

      StHalt: begin
        if (start) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and output registers; reset is asynchronous so a mid-game reset clears immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      x_q     <= ScreenW;
      y_q     <= GapMinH;
      score_q <= 8'd0;
      pulse_q <= 1'b0;
      lfsr_q  <= LfsrSeed;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      score_q <= score_d;
      pulse_q <= pulse_d;
      lfsr_q  <= lfsr_d;
    end
  end

  // Outputs come straight from registers; status flags decode the registered state.
  always_comb begin
    pipe_x      = x_q;
    pipe_y      = y_q;
    score       = score_q;
    score_pulse = pulse_q;
    running     = (state_q == StRun);
    pipe_valid  = (state_q != StIdle);
  end

endmodule

// File: tb/tb_pipe_scroller.sv
// Bench for pipe_scroller: directed stimulus drives a small game model that pushes the expected
// outputs for every stimulated cycle into a queue; a separate monitor pops and compares them.
// Hand-computed milestone values are also checked directly.
module tb_pipe_scroller;

  logic       clk = 1'b0;
  logic       reset;
  logic       frame_tick;
  logic       start;
  logic       collision;
  logic [9:0] pipe_x;
  logic [9:0] pipe_y;
  logic       pipe_valid;
  logic       running;
  logic       score_pulse;
  logic [7:0] score;

  always #5 clk = ~clk;

  pipe_scroller dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .start      (start),
    .collision  (collision),
    .pipe_x     (pipe_x),
    .pipe_y     (pipe_y),
    .pipe_valid (pipe_valid),
    .running    (running),
    .score_pulse(score_pulse),
    .score      (score)
  );

  typedef struct {
    int x;
    int y;
    int score;
    int pulse;
    int running;
    int valid;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   pulse_count = 0;

  // Game model state (0 idle, 1 run, 2 halt).
  int          m_st;
  int          m_x;
  int          m_y;
  int          m_score;
  int          m_pulse;
  logic [15:0] m_lfsr;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      if (n_fail <= 25) $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_st    = 0;
    m_x     = 640;
    m_y     = 40;
    m_score = 0;
    m_pulse = 0;
    m_lfsr  = 16'hACE1;
  endtask

  task automatic model_load();
    m_x    = 640;
    m_y    = 40 + int'(m_lfsr[7:0]);
    m_lfsr = lfsr_adv(m_lfsr);
  endtask

  task automatic model_step(input logic t, input logic s, input logic c);
    int ox;
    m_pulse = 0;
    case (m_st)
      0: if (s) begin
        m_st = 1;
        model_load();
        m_score = 0;
      end
      1: if (c) begin
        m_st = 2;
      end else if (t) begin
        if (m_x <= 2) begin
          model_load();
        end else begin
          ox  = m_x;
          m_x = m_x - 2;
          if (ox + 40 > 100 && m_x + 40 <= 100) begin
            m_pulse = 1;
            if (m_score < 255) m_score++;
          end
        end
      end
      default: if (s) m_st = 0;
    endcase
  endtask

  // One clock of stimulus: drive at the falling edge, queue the expectation, release afterwards.
  task automatic cycle(input logic t, input logic s, input logic c);
    exp_t e;
    @(negedge clk);
    frame_tick = t;
    start      = s;
    collision  = c;
    model_step(t, s, c);
    e.x       = m_x;
    e.y       = m_y;
    e.score   = m_score;
    e.pulse   = m_pulse;
    e.running = (m_st == 1) ? 1 : 0;
    e.valid   = (m_st != 0) ? 1 : 0;
    q.push_back(e);
    @(posedge clk);
    #2;
    frame_tick = 1'b0;
    start      = 1'b0;
    collision  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_x"}, int'(pipe_x), 640);
    chk({tag, "_y"}, int'(pipe_y), 40);
    chk({tag, "_valid"}, int'(pipe_valid), 0);
    chk({tag, "_running"}, int'(running), 0);
    chk({tag, "_score"}, int'(score), 0);
    chk({tag, "_pulse"}, int'(score_pulse), 0);
  endtask

  // Monitor: one sample per cycle just after the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (score_pulse) pulse_count++;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("mon_x", int'(pipe_x), e.x);
        chk("mon_y", int'(pipe_y), e.y);
        chk("mon_score", int'(score), e.score);
        chk("mon_pulse", int'(score_pulse), e.pulse);
        chk("mon_running", int'(running), e.running);
        chk("mon_valid", int'(pipe_valid), e.valid);
      end
    end
  end

  initial begin
    reset      = 1'b0;
    frame_tick = 1'b0;
    start      = 1'b0;
    collision  = 1'b0;
    model_reset();
    #12;
    check_reset_values("por");
    @(negedge clk);
    reset = 1'b1;

    // Ticks in IDLE do nothing.
    cycle(1, 0, 0);
    cycle(1, 0, 1);

    // Start: first gap from seed 0xACE1 -> 40 + 0xE1.
    cycle(0, 1, 0);
    chk("start_x", int'(pipe_x), 640);
    chk("start_y", int'(pipe_y), 265);
    chk("start_running", int'(running), 1);
    chk("start_valid", int'(pipe_valid), 1);
    chk("start_score", int'(score), 0);

    for (int i = 0; i < 290; i++) cycle(1, 0, 0);
    chk("t290_x", int'(pipe_x), 60);
    chk("t290_pulse", int'(score_pulse), 1);
    chk("t290_score", int'(score), 1);
    chk("t290_pulses", pulse_count, 1);

    for (int i = 0; i < 29; i++) cycle(1, 0, 0);
    chk("t319_x", int'(pipe_x), 2);
    chk("t319_pulses", pulse_count, 1);
    // Respawn: LFSR 0xACE1 -> 0xE270, gap = 40 + 0x70.
    cycle(1, 0, 0);
    chk("t320_x", int'(pipe_x), 640);
    chk("t320_y", int'(pipe_y), 152);
    chk("t320_pulse", int'(score_pulse), 0);

    // Collision beats a same-cycle tick, then HALT ignores ticks and collision.
    for (int i = 0; i < 5; i++) cycle(1, 0, 0);
    cycle(1, 0, 1);
    chk("halt_x", int'(pipe_x), 630);
    chk("halt_running", int'(running), 0);
    chk("halt_valid", int'(pipe_valid), 1);
    chk("halt_pulse", int'(score_pulse), 0);
    cycle(1, 0, 0);
    cycle(1, 0, 1);
    cycle(1, 0, 0);
    chk("halt_hold_x", int'(pipe_x), 630);
    cycle(0, 1, 0);
    chk("idle_running", int'(running), 0);
    chk("idle_valid", int'(pipe_valid), 0);
    chk("idle_hold_x", int'(pipe_x), 630);
    // Restart: LFSR 0xE270 -> 0x7138, gap = 40 + 0x38.
    cycle(0, 1, 0);
    chk("restart_x", int'(pipe_x), 640);
    chk("restart_y", int'(pipe_y), 96);
    chk("restart_score", int'(score), 0);
    cycle(1, 1, 0);

    // Long run: the 256th pipe passes on tick 255*320+290 counted from the restart.
    pulse_count = 0;
    for (int i = 1; i < 255 * 320 + 290; i++) cycle(1, 0, 0);
    chk("sat_score", int'(score), 255);
    chk("sat_pulse", int'(score_pulse), 1);
    chk("sat_pulses", pulse_count, 256);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) cycle(1, 0, 0);
    #1;
    reset = 1'b0;
    #1;
    check_reset_values("async");
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    cycle(1, 0, 0);
    chk("post_reset_x", int'(pipe_x), 640);
    chk("post_reset_running", int'(running), 0);

    @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Generates the single on-screen pipe for the game: holds a run/idle/halt state machine, scrolls the pipe left by a fixed step on every frame tick, respawns it at the right edge with a pseudo-random gap height from an LFSR, and counts score when the pipe passes the bird. Sits directly upstream of the collision stage, driving its `pipe_x`/`pipe_y` inputs, and consumes that stage's `collision_out` to freeze the game.

## Interface
- `WIDTH`, 10: bit width of x coordinates.
- `HEIGHT`, 10: bit width of y coordinates.
- `SCREEN_W`, 640: respawn x position; must be < 2^WIDTH.
- `PIPE_WIDTH`, 40: pipe width in pixels, used for scoring.
- `BIRD_X`, 100: fixed bird x position, used for scoring.
- `SPEED`, 2: pixels moved per frame tick; must be ≥ 1.
- `GAP_MIN`, 40: minimum gap top y; GAP_MIN+255 must fit in HEIGHT bits.
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-low.
- `frame_tick`  in  1  one-cycle pulse per video frame.
- `start`  in  1  one-cycle start/restart request.
- `collision`  in  1  level from the collision stage.
- `pipe_x`  out  WIDTH  pipe left edge.
- `pipe_y`  out  HEIGHT  gap top edge.
- `pipe_valid`  out  1  high in RUN and HALT.
- `running`  out  1  high only in RUN.
- `score_pulse`  out  1  one-cycle pulse per pipe passed.
- `score`  out  8  pipes passed; saturates at 255.

## Operation
- States: IDLE, RUN, HALT. Reset (reset=0) forces IDLE, pipe_x=SCREEN_W, pipe_y=GAP_MIN, pipe_valid=0, running=0, score=0, score_pulse=0, lfsr=16'hACE1. Reset asserted mid-game returns everything to these values immediately.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1 (right shift, XOR mask 16'hB400 when the shifted-out bit is 1). Advances only on a gap load. Never reaches zero.
- Gap load: pipe_y ← GAP_MIN + lfsr[7:0] (current value), pipe_x ← SCREEN_W, lfsr advances in the same cycle.
- IDLE → RUN on start: gap load, score ← 0. frame_tick and collision are ignored in IDLE.
- RUN, collision=1 → HALT. pipe_x, pipe_y and score hold. Collision has priority over a same-cycle frame_tick: no move, no score.
- RUN, frame_tick, no collision:
  - If pipe_x ≤ SPEED: gap load (respawn), no score.
  - Else: pipe_x ← pipe_x − SPEED. If old pipe_x+PIPE_WIDTH > BIRD_X and new pipe_x+PIPE_WIDTH ≤ BIRD_X, assert score_pulse and increment score (saturating at 255; the pulse still fires at 255). Compute sums in WIDTH+1 bits.
- start is ignored in RUN.
- HALT → IDLE on start. pipe_x/pipe_y/score hold until the next IDLE → RUN.
- collision and frame_tick are ignored in HALT.

## Timing
- All outputs are registered. pipe_x, pipe_y, score and score_pulse update on the clock edge that samples frame_tick/start, so they are visible 1 cycle later.
- score_pulse is exactly 1 cycle wide and coincides with the updated pipe_x.
- running and pipe_valid change on the same edge as the state transition.
- collision is sampled as a level every cycle in RUN. The HALT entry freezes the outputs 1 cycle after collision is seen.
- frame_tick pulses closer together than 1 cycle are not supported. Back-to-back ticks on consecutive cycles must each move the pipe.

## Test plan
- Reset, then start: 1 cycle later pipe_x=640, pipe_y=265 (40+0xE1), running=1, pipe_valid=1, score=0.
- After start, 290 frame_ticks: pipe_x=60; score_pulse fires on tick 290 only; score=1.
- Continue to tick 319 (pipe_x=2). Tick 320: pipe_x=640, pipe_y=40+next lfsr[7:0] (per the bench model), no score_pulse.
- In RUN, collision and frame_tick in the same cycle: state becomes HALT, pipe_x unchanged, no pulse. Further ticks leave pipe_x unchanged. start → IDLE, then start again → pipe_x=640, score=0.
- Run 300 pipes with forced score=254 (or a long run): score goes 254→255→255 while pulses continue.
- Deassert reset (drive low) mid-RUN between clock edges: outputs return to reset values without a clock edge; frame_tick in IDLE causes no change.
